// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared encodings and control-bundle types for the pipeline
// control backbone.
//   ALUOP_* : ALU class carried with each instruction
//   FWD_*   : EX operand source selects produced by fwd_unit
//   *_ctrl_t: control fields kept in the ID/EX, EX/MEM and MEM/WB registers
package ctrl_pkg;

   localparam logic [1:0] ALUOP_I  = 2'b00;
   localparam logic [1:0] ALUOP_S  = 2'b01;
   localparam logic [1:0] ALUOP_R  = 2'b10;
   localparam logic [1:0] ALUOP_SB = 2'b11;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       memto_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic memto_reg;
      logic mem_read;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic memto_reg;
   } wb_ctrl_t;

   // A bubble does nothing: every enable low, ALU class left at R-type.
   function automatic ex_ctrl_t bubble_ctrl();
      ex_ctrl_t b;
      b        = '0;
      b.alu_op = ALUOP_R;
      return b;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit -- combinational EX-stage forwarding compare for both operands.
//   ex_rs1, ex_rs2         : source registers of the instruction in EX
//   mem_reg_write, mem_rd  : writer currently in MEM
//   wb_reg_write,  wb_rd   : writer currently in WB
//   fwd_a, fwd_b           : operand source selects (FWD_RF/FWD_WB/FWD_MEM)
module fwd_unit
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   // The younger result (MEM) wins over the older one (WB); x0 is never
   // forwarded because writes to it are discarded.
   function automatic logic [1:0] select_src(input logic [REG_AW-1:0] rs);
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
         return FWD_MEM;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   assign fwd_a = select_src(ex_rs1);
   assign fwd_b = select_src(ex_rs2);

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline -- control backbone of the five-stage core.
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   *_i bundle, rs/rd    : decoded ID-stage control and register indices
//   flush_i              : branch taken (resolved in ID)
//   mem_stall_i          : data memory busy, freezes every stage
//   NoOp_o, PCWrite_o,
//   IFIDWrite_o, IFFlush_o : hazard/flush controls toward fetch and decode
//   ex_*, mem_*, wb_*    : registered ID/EX, EX/MEM, MEM/WB control
//   ForwardA_o/B_o       : EX operand source selects
module ctrl_pipeline
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              RegWrite_i,
   input  logic              MemtoReg_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              ALUSrc_i,
   input  logic              Branch_i,
   input  logic [1:0]        ALUOp_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              flush_i,
   input  logic              mem_stall_i,
   output logic              NoOp_o,
   output logic              PCWrite_o,
   output logic              IFIDWrite_o,
   output logic              IFFlush_o,
   output logic              ex_RegWrite_o,
   output logic              ex_MemtoReg_o,
   output logic              ex_MemRead_o,
   output logic              ex_MemWrite_o,
   output logic              ex_ALUSrc_o,
   output logic [1:0]        ex_ALUOp_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [1:0]        ForwardA_o,
   output logic [1:0]        ForwardB_o,
   output logic              mem_RegWrite_o,
   output logic              mem_MemtoReg_o,
   output logic              mem_MemRead_o,
   output logic              mem_MemWrite_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic              wb_RegWrite_o,
   output logic              wb_MemtoReg_o,
   output logic [REG_AW-1:0] wb_rd_o
);

   ex_ctrl_t          ex_q;
   mem_ctrl_t         mem_q;
   wb_ctrl_t          wb_q;
   logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q, mem_rd_q, wb_rd_q;
   ex_ctrl_t          id_ctrl;
   logic              hazard;

   // Branches resolve in ID, so Branch_i is not carried past decode.
   logic unused_branch;
   assign unused_branch = Branch_i;

   assign id_ctrl = '{reg_write: RegWrite_i, memto_reg: MemtoReg_i,
                      mem_read:  MemRead_i,  mem_write: MemWrite_i,
                      alu_src:   ALUSrc_i,   alu_op:    ALUOp_i};

   // Load in EX whose result the instruction in ID needs.
   assign hazard = ex_q.mem_read && (ex_rd_q != '0) &&
                   ((ex_rd_q == rs1_i) || (ex_rd_q == rs2_i));

   // NOTE: every output gets a default first so no path through the block
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      NoOp_o      = 1'b0;
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IFFlush_o   = flush_i;
      if (mem_stall_i) begin
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         IFFlush_o   = 1'b0;
      end else if (hazard) begin
         // The branch re-resolves next cycle, so its flush waits too.
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         IFFlush_o   = 1'b0;
      end
   end

   // NOTE: stage registers use non-blocking assignments so every stage
   // samples the previous stage's pre-edge value.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: only control state is reset; an empty pipeline is all
         // bubbles, which is what lets a mid-stall reset start clean.
         ex_q     <= bubble_ctrl();
         ex_rd_q  <= '0;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         mem_q    <= '0;
         mem_rd_q <= '0;
         wb_q     <= '0;
         wb_rd_q  <= '0;
      end else if (!mem_stall_i) begin
         if (hazard) begin
            ex_q     <= bubble_ctrl();
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
         end else begin
            ex_q     <= id_ctrl;
            ex_rd_q  <= rd_i;
            ex_rs1_q <= rs1_i;
            ex_rs2_q <= rs2_i;
         end
         mem_q    <= '{reg_write: ex_q.reg_write, memto_reg: ex_q.memto_reg,
                       mem_read:  ex_q.mem_read,  mem_write: ex_q.mem_write};
         mem_rd_q <= ex_rd_q;
         wb_q     <= '{reg_write: mem_q.reg_write, memto_reg: mem_q.memto_reg};
         wb_rd_q  <= mem_rd_q;
      end
   end

   fwd_unit #(.REG_AW(REG_AW)) u_fwd (
      .ex_rs1        (ex_rs1_q),
      .ex_rs2        (ex_rs2_q),
      .mem_reg_write (mem_q.reg_write),
      .mem_rd        (mem_rd_q),
      .wb_reg_write  (wb_q.reg_write),
      .wb_rd         (wb_rd_q),
      .fwd_a         (ForwardA_o),
      .fwd_b         (ForwardB_o)
   );

   assign ex_RegWrite_o  = ex_q.reg_write;
   assign ex_MemtoReg_o  = ex_q.memto_reg;
   assign ex_MemRead_o   = ex_q.mem_read;
   assign ex_MemWrite_o  = ex_q.mem_write;
   assign ex_ALUSrc_o    = ex_q.alu_src;
   assign ex_ALUOp_o     = ex_q.alu_op;
   assign ex_rd_o        = ex_rd_q;
   assign mem_RegWrite_o = mem_q.reg_write;
   assign mem_MemtoReg_o = mem_q.memto_reg;
   assign mem_MemRead_o  = mem_q.mem_read;
   assign mem_MemWrite_o = mem_q.mem_write;
   assign mem_rd_o       = mem_rd_q;
   assign wb_RegWrite_o  = wb_q.reg_write;
   assign wb_MemtoReg_o  = wb_q.memto_reg;
   assign wb_rd_o        = wb_rd_q;

endmodule
